// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game sequencer for the frog/car VGA display.
// Owns the frog and car grid positions, advances them once per frame_tick,
// checks for collisions and goal arrival on the cycle after each update, and
// keeps lives and score. All outputs come straight from registers.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per frame (vblank start)
//   start             level; starts a game from IDLE
//   btn_up/down/left/right  synchronized button levels
//   frog_col, frog_row      frog grid cell
//   cars_x            car k column at [5k+4:5k], k = 0..10
//   cars_y            car k row at [4k+3:4k] (constant k+2)
//   state             0=IDLE 1=PLAY 2=HIT 3=WIN
//   lives, score      remaining lives, goals reached (saturating)
//
// Build option
//   LEVEL_SPEEDUP_EN  adds a 2-bit level that shortens car periods after wins.
module frog_game_ctrl #(
    parameter int unsigned COLS        = 20,
    parameter int unsigned ROWS        = 15,
    parameter int unsigned START_COL   = 10,
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned SPEED_BASE  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [4:0]  frog_col,
    output logic [3:0]  frog_row,
    output logic [54:0] cars_x,
    output logic [43:0] cars_y,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [7:0]  score
);

    localparam int unsigned NCARS = 11;
    localparam int unsigned CW    = 5;
    localparam int unsigned RW    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned HW    = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    localparam logic [CW-1:0] SPAWN_COL = CW'(START_COL);
    localparam logic [RW-1:0] SPAWN_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] MAX_COL   = CW'(COLS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [1:0]    LIVES_RST = 2'(LIVES_INIT);

    // Car k spawn column
    function automatic logic [CW-1:0] car_init_x(input int unsigned k);
        return CW'((7 * k) % COLS);
    endfunction

    // Car k lane row (fixed)
    function automatic logic [RW-1:0] car_row(input int unsigned k);
        return RW'(k + 2);
    endfunction

    // Car k step period in frames, floored at 1
    function automatic logic [DW-1:0] car_period(input int unsigned k, input logic [1:0] lvl);
        int p;
        p = int'(SPEED_BASE) + int'(k % 4) - int'(lvl);
        if (p < 1) begin
            p = 1;
        end
        return DW'(p);
    endfunction

    // One column step: even cars move right, odd cars move left, both wrap
    function automatic logic [CW-1:0] step_x(input int unsigned k, input logic [CW-1:0] x);
        if ((k % 2) == 0) begin
            return (x == MAX_COL) ? CW'(0) : x + CW'(1);
        end
        return (x == CW'(0)) ? MAX_COL : x - CW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] frog_col_q, frog_col_d;
    logic [RW-1:0] frog_row_q, frog_row_d;
    logic [CW-1:0] car_x_q [NCARS];
    logic [CW-1:0] car_x_d [NCARS];
    logic [DW-1:0] div_q   [NCARS];
    logic [DW-1:0] div_d   [NCARS];
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    btn_prev_q;
    logic [3:0]    pend_q, pend_d;
    logic          check_q, check_d;

    logic [3:0]    btn_now;
    logic [3:0]    btn_edge;
    logic          hit_c;
    logic          goal_c;
    logic          hold_done_c;
    logic          step_c;
    logic [1:0]    level_c;

`ifdef LEVEL_SPEEDUP_EN
    logic [1:0]    level_q, level_d;
    assign level_c = level_q;
`else
    assign level_c = 2'd0;
`endif

    // Button bit order: up, down, left, right (highest bit wins)
    assign btn_now     = {btn_up, btn_down, btn_left, btn_right};
    assign btn_edge    = btn_now & ~btn_prev_q;
    assign goal_c      = (frog_row_q == RW'(0));
    assign hold_done_c = frame_tick && (hold_q == HOLD_LAST);
    // Movement is suppressed on a tick that coincides with a HIT/WIN decision
    assign step_c      = (state_q == ST_PLAY) && frame_tick && (state_d == ST_PLAY);

    // Frog shares a cell with any car
    always_comb begin
        hit_c = 1'b0;
        for (int unsigned k = 0; k < NCARS; k++) begin
            if ((frog_col_q == car_x_q[k]) && (frog_row_q == car_row(k))) begin
                hit_c = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // collision outranks goal
                if (check_q) begin
                    if (hit_c) begin
                        state_d = ST_HIT;
                    end else if (goal_c) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_HIT: begin
                if (hold_done_c) begin
                    state_d = (lives_q <= 2'd1) ? ST_IDLE : ST_PLAY;
                end
            end
            ST_WIN: begin
                if (hold_done_c) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        logic [DW-1:0] per;
        per        = '0;
        frog_col_d = frog_col_q;
        frog_row_d = frog_row_q;
        hold_d     = hold_q;
        lives_d    = lives_q;
        score_d    = score_q;
        check_d    = 1'b0;
        for (int unsigned k = 0; k < NCARS; k++) begin
            car_x_d[k] = car_x_q[k];
            div_d[k]   = div_q[k];
        end
`ifdef LEVEL_SPEEDUP_EN
        level_d = level_q;
`endif
        // Edges seen with the tick belong to the next frame
        pend_d = frame_tick ? btn_edge : (pend_q | btn_edge);

        if (step_c) begin
            check_d = 1'b1;
            if (pend_q[3]) begin
                if (frog_row_q != RW'(0)) frog_row_d = frog_row_q - RW'(1);
            end else if (pend_q[2]) begin
                if (frog_row_q != SPAWN_ROW) frog_row_d = frog_row_q + RW'(1);
            end else if (pend_q[1]) begin
                if (frog_col_q != CW'(0)) frog_col_d = frog_col_q - CW'(1);
            end else if (pend_q[0]) begin
                if (frog_col_q != MAX_COL) frog_col_d = frog_col_q + CW'(1);
            end
            for (int unsigned k = 0; k < NCARS; k++) begin
                per = car_period(k, level_c);
                // >= keeps a divider sane if the period shrinks under it
                if (div_q[k] >= (per - DW'(1))) begin
                    div_d[k]   = '0;
                    car_x_d[k] = step_x(k, car_x_q[k]);
                end else begin
                    div_d[k] = div_q[k] + DW'(1);
                end
            end
        end

        if ((state_q == ST_PLAY) && (state_d == ST_WIN)) begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef LEVEL_SPEEDUP_EN
            if (level_q != 2'd3) level_d = level_q + 2'd1;
`endif
        end

        if (((state_q == ST_HIT) || (state_q == ST_WIN)) && frame_tick) begin
            hold_d = hold_q + HW'(1);
            if (hold_done_c) begin
                hold_d     = '0;
                frog_col_d = SPAWN_COL;
                frog_row_d = SPAWN_ROW;
                if (state_q == ST_HIT) begin
                    lives_d = lives_q - 2'd1;
                    // game over: everything but score returns to reset
                    if (state_d == ST_IDLE) begin
                        lives_d = LIVES_RST;
                        for (int unsigned k = 0; k < NCARS; k++) begin
                            car_x_d[k] = car_init_x(k);
                            div_d[k]   = '0;
                        end
`ifdef LEVEL_SPEEDUP_EN
                        level_d = 2'd0;
`endif
                    end
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            frog_col_q <= SPAWN_COL;
            frog_row_q <= SPAWN_ROW;
            hold_q     <= '0;
            lives_q    <= LIVES_RST;
            score_q    <= '0;
            btn_prev_q <= '0;
            pend_q     <= '0;
            check_q    <= 1'b0;
            for (int unsigned k = 0; k < NCARS; k++) begin
                car_x_q[k] <= car_init_x(k);
                div_q[k]   <= '0;
            end
`ifdef LEVEL_SPEEDUP_EN
            level_q <= 2'd0;
`endif
        end else begin
            frog_col_q <= frog_col_d;
            frog_row_q <= frog_row_d;
            hold_q     <= hold_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            btn_prev_q <= btn_now;
            pend_q     <= pend_d;
            check_q    <= check_d;
            for (int unsigned k = 0; k < NCARS; k++) begin
                car_x_q[k] <= car_x_d[k];
                div_q[k]   <= div_d[k];
            end
`ifdef LEVEL_SPEEDUP_EN
            level_q <= level_d;
`endif
        end
    end

    // Output packing
    always_comb begin
        cars_x = '0;
        cars_y = '0;
        for (int unsigned k = 0; k < NCARS; k++) begin
            cars_x[k*CW +: CW] = car_x_q[k];
            cars_y[k*RW +: RW] = car_row(k);
        end
    end

    assign frog_col = frog_col_q;
    assign frog_row = frog_row_q;
    assign state    = state_q;
    assign lives    = lives_q;
    assign score    = score_q;

endmodule
